// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  id;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the requester that did not win last goes first.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // r_last resets to 1 so requester 0 takes the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_last <= 1'b1;
    else if (accept) r_last <= gnt[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a 256x8 synchronous single-port memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            r_state;
  state_t            w_next;
  cmd_t              r_cmd;
  cmd_t              w_cmd_in;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rsp_data;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_req    = {req1_valid, req0_valid} & {2{w_idle}};
  assign w_accept = w_idle && (w_gnt != 2'b00);

  // ready is masked by reset so every output reads 0 while reset is held
  assign req0_ready = w_gnt[0] & w_idle & ~reset;
  assign req1_ready = w_gnt[1] & w_idle & ~reset;

  rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  always_comb begin
    w_cmd_in.write = w_gnt[1] ? req1_write : req0_write;
    w_cmd_in.addr  = w_gnt[1] ? req1_addr  : req0_addr;
    w_cmd_in.wdata = w_gnt[1] ? req1_wdata : req0_wdata;
    w_cmd_in.id    = w_gnt[1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)            r_cmd   <= w_cmd_in;
      if (r_state == CAPTURE)  r_rdata <= mem_data_out;
    end
  end

  assign w_rsp_data = r_cmd.write ? '0 : r_rdata;

  always_comb begin
    w_next      = r_state;
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    rsp0_valid  = 1'b0;
    rsp0_rdata  = '0;
    rsp1_valid  = 1'b0;
    rsp1_rdata  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        mem_enable  = 1'b1;
        mem_write   = r_cmd.write;
        mem_address = r_cmd.addr;
        mem_data_in = r_cmd.wdata;
        w_next      = r_cmd.write ? RESP : CAPTURE;
      end
      CAPTURE: begin
        // Re-issue the read so data_out holds while it is registered at exit
        mem_enable  = 1'b1;
        mem_address = r_cmd.addr;
        w_next      = RESP;
      end
      RESP: begin
        if (r_cmd.id) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = w_rsp_data;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = w_rsp_data;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural 256x8 memory, vector table and response scoreboard.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 0, req0_write = 0, req0_ready;
  logic [7:0] req0_addr = 0, req0_wdata = 0;
  logic       req1_valid = 0, req1_write = 0, req1_ready;
  logic [7:0] req1_addr = 0, req1_wdata = 0;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_write, mem_enable;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic       id;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] rdata;
    int         lat;
    int         t_ready;
  } sb_t;

  sb_t  sb_q[$];
  int   grant_q[$];
  logic [7:0] mem [256];

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_enable(mem_enable), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port memory; data_out reads 0 while disabled
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  initial mem_data_out = 8'h00;
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem_write ? 8'h00 : mem[mem_address];
    end else begin
      mem_data_out <= 8'h00;
    end
  end

  // Response monitor and scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      n_chk++;
      if (req0_ready && req1_ready) begin
        n_fail++;
        $display("FAIL ready_exclusive: both ready high at cycle %0d", cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        n_chk++;
        if (rsp0_valid && rsp1_valid) begin
          n_fail++;
          $display("FAIL rsp_exclusive: both rsp_valid high at cycle %0d", cyc);
        end else if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: rsp0=%0b rsp1=%0b with nothing outstanding", rsp0_valid, rsp1_valid);
        end else begin
          sb_t  e;
          logic id;
          logic [7:0] rd, other;
          e     = sb_q.pop_front();
          id    = rsp1_valid;
          rd    = id ? rsp1_rdata : rsp0_rdata;
          other = id ? rsp0_rdata : rsp1_rdata;
          if (id != e.id || rd != e.rdata || other != 8'h00 || (cyc - e.t_ready) != e.lat) begin
            n_fail++;
            $display("FAIL rsp_check: got id=%0d rdata=%02h other=%02h lat=%0d, want id=%0d rdata=%02h other=00 lat=%0d",
                     id, rd, other, cyc - e.t_ready, e.id, e.rdata, e.lat);
          end
        end
      end
    end
  end

  task automatic set_req(input logic id, input logic v, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic do_cmd(input logic id, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp, output int t_rdy);
    bit got = 0;
    t_rdy = -1;
    @(negedge clock);
    set_req(id, 1'b1, wr, a, d);
    for (int k = 0; k < 40 && !got; k++) begin
      #1;
      if ((id ? req1_ready : req0_ready) == 1'b1) begin
        got   = 1;
        t_rdy = cyc;
        grant_q.push_back(int'(id));
        sb_q.push_back('{id, exp, (wr ? 2 : 3), cyc});
      end else begin
        @(negedge clock);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL grant_timeout: req%0d got ready=0, want 1 within 40 cycles", id);
    end else begin
      @(posedge clock);
      #1;
    end
    set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 30) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   t, t_prev;
    logic [7:0] b2b_addr[4];
    logic [7:0] b2b_exp[4];
    logic [43:0] outs;
    bit got;

    // Reset held with random inputs: every output must read 0
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req0_write = 1'($urandom_range(0, 1));
      req0_addr  = 8'($urandom);             req0_wdata = 8'($urandom);
      req1_valid = 1'($urandom_range(0, 1)); req1_write = 1'($urandom_range(0, 1));
      req1_addr  = 8'($urandom);             req1_wdata = 8'($urandom);
      #3;
      outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
              mem_address, mem_data_in, mem_write, mem_enable};
      n_chk++;
      if (outs != 44'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %011h, want 0", outs);
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset: no memory activity
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_chk++;
      if (mem_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_enable: mem_enable=%0b, want 0", mem_enable);
      end
    end

    // Contention: both valid continuously; grants must alternate starting with 0
    grant_q.delete();
    fork
      begin
        do_cmd(1'b0, 1'b1, 8'h20, 8'h11, 8'h00, t);
        do_cmd(1'b0, 1'b1, 8'h22, 8'h33, 8'h00, t);
      end
      begin
        do_cmd(1'b1, 1'b1, 8'h21, 8'h22, 8'h00, t_prev);
        do_cmd(1'b1, 1'b1, 8'h23, 8'h44, 8'h00, t_prev);
      end
    join
    drain();
    n_chk++;
    if (grant_q.size() != 4 || grant_q[0] != 0 || grant_q[1] != 1 || grant_q[2] != 0 || grant_q[3] != 1) begin
      n_fail++;
      $display("FAIL grant_order: got %p, want '{0,1,0,1}", grant_q);
    end

    // Table: write/read across requesters and address boundaries
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'hC3, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 8'h7F, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, t);
      drain();
    end

    // Solo back-to-back reads from requester 0: regranted every 4 cycles
    b2b_addr = '{8'h10, 8'h00, 8'hFF, 8'h20};
    b2b_exp  = '{8'hA5, 8'h3C, 8'hC3, 8'h11};
    t_prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 1'b0, b2b_addr[i], 8'h00, b2b_exp[i], t);
      if (i > 0) begin
        n_chk++;
        if (t - t_prev != 4) begin
          n_fail++;
          $display("FAIL b2b_spacing: read %0d regranted after %0d cycles, want 4", i, t - t_prev);
        end
      end
      t_prev = t;
    end
    drain();

    // Reset during CAPTURE aborts the read; the held valid is regranted afterwards
    @(negedge clock);
    set_req(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req1_ready) got = 1;
      else @(negedge clock);
    end
    @(posedge clock);
    @(posedge clock);
    #2;
    n_chk++;
    if (!got || mem_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_enable: got ready=%0b mem_enable=%0b, want 1 1", got, mem_enable);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({mem_enable, mem_address, rsp0_valid, rsp1_valid} !== 11'h0) begin
      n_fail++;
      $display("FAIL async_abort: mem_enable=%0b addr=%02h rsp0=%0b rsp1=%0b, want all 0",
               mem_enable, mem_address, rsp0_valid, rsp1_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req1_ready) begin
        got = 1;
        sb_q.push_back('{1'b1, 8'hA5, 3, cyc});
      end else begin
        @(negedge clock);
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL regrant_after_reset: ready=0, want 1 within 20 cycles");
    end
    @(posedge clock);
    #1;
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drain();
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
